color_percent_scheduler: RTL and testbench

- Sequences the shared PercentCalculator divider across the three color-sensor channels (red, green, blue).
- Each channel's share of the R+G+B total is computed as a rounded percentage.
- Latches one measurement set, pre-scales the counts so the divider cannot overflow, then runs three divides back-to-back.
- Publishes all three results together with a one-cycle valid pulse. Sits between the frequency counters and the display/decision logic.

---
 rtl/color_percent_scheduler_pkg.sv | 21 ++
 rtl/color_percent_scheduler_if.sv | 23 ++
 rtl/color_percent_scheduler_timer.sv | 25 ++
 rtl/color_percent_scheduler.sv | 148 ++++++++++++++
 tb/tb_color_percent_scheduler.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/color_percent_scheduler_pkg.sv
// Shared types and constants for the color percentage scheduler.
package color_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SUM    = 3'd1,
      SCALE  = 3'd2,
      LAUNCH = 3'd3,
      WAIT   = 3'd4,
      GAP    = 3'd5,
      DONE   = 3'd6
   } state_t;

   localparam logic [1:0] CH_RED   = 2'd0;
   localparam logic [1:0] CH_GREEN = 2'd1;
   localparam logic [1:0] CH_BLUE  = 2'd2;

   localparam int PCT_W = 10;
   localparam int DIV_W = 21;

endpackage

// File: rtl/color_percent_scheduler_if.sv
// Bus between the scheduler and the shared PercentCalculator divider.
interface color_percent_scheduler_if;
   import color_pkg::*;

   logic [DIV_W-1:0] dividend;
   logic [DIV_W-1:0] divisor;
   logic             per_on;
   logic             per_done;
   logic [PCT_W-1:0] percentage;

   // scheduler side drives the operands and the enable
   modport master (
      output dividend, divisor, per_on,
      input  per_done, percentage
   );

   // divider side returns the result
   modport slave (
      input  dividend, divisor, per_on,
      output per_done, percentage
   );

endinterface

// File: rtl/color_percent_scheduler_timer.sv
// Per-channel watchdog: counts divider wait cycles and flags when the
// allowed budget is used up.
module pct_timeout_timer #(
   parameter int TIMEOUT = 255,
   parameter int TMR_W   = 8
) (
   input  logic CLK100MHZ,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TMR_W-1:0] cnt;

   assign expired = (cnt == TMR_W'(TIMEOUT));

   // count enabled cycles, saturating at the limit
   always_ff @(posedge CLK100MHZ or negedge reset_n) begin
      if (!reset_n)                cnt <= '0;
      else if (clear)              cnt <= '0;
      else if (enable && !expired) cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/color_percent_scheduler.sv
// Time-shares one divider across red/green/blue to produce each channel's
// rounded percentage of the total, publishing all three at once.
module color_percent_scheduler
   import color_pkg::*;
#(
   parameter int COUNT_W   = 16,
   parameter int MAX_TOTAL = 5000,
   parameter int TIMEOUT   = 255,
   parameter int TMR_W     = 8
) (
   input  logic                    CLK100MHZ,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [COUNT_W-1:0]      red_cnt,
   input  logic [COUNT_W-1:0]      green_cnt,
   input  logic [COUNT_W-1:0]      blue_cnt,
   color_percent_scheduler_if.master div,
   output logic [PCT_W-1:0]        red_pct,
   output logic [PCT_W-1:0]        green_pct,
   output logic [PCT_W-1:0]        blue_pct,
   output logic                    pct_valid,
   output logic                    busy,
   output logic                    zero_flag,
   output logic                    error
);

   localparam int TOT_W = COUNT_W + 2;
   localparam logic [TOT_W-1:0] MAX_T = TOT_W'(MAX_TOTAL);

   state_t                        state;
   logic [2:0][COUNT_W-1:0]       chan;
   logic [2:0][PCT_W-1:0]         res;
   logic [TOT_W-1:0]              total;
   logic [1:0]                    idx;
   logic [1:0]                    idx_nxt;
   logic                          zero_pend;
   logic                          err_pend;
   logic                          tmr_expired;

   assign idx_nxt = idx + 2'd1;

   pct_timeout_timer #(
      .TIMEOUT (TIMEOUT),
      .TMR_W   (TMR_W)
   ) u_timer (
      .CLK100MHZ (CLK100MHZ),
      .reset_n   (reset_n),
      .clear     (state == LAUNCH),
      .enable    (state == WAIT),
      .expired   (tmr_expired)
   );

   // Sequencer. Divider operands and per_on are loaded on the transition
   // into LAUNCH so they are already valid while LAUNCH is the state; that
   // keeps per_on low for only the single GAP cycle between channels.
   always_ff @(posedge CLK100MHZ or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         chan         <= '0;
         res          <= '0;
         total        <= '0;
         idx          <= CH_RED;
         zero_pend    <= 1'b0;
         err_pend     <= 1'b0;
         div.dividend <= '0;
         div.divisor  <= '0;
         div.per_on   <= 1'b0;
         red_pct      <= '0;
         green_pct    <= '0;
         blue_pct     <= '0;
         pct_valid    <= 1'b0;
         busy         <= 1'b0;
         zero_flag    <= 1'b0;
         error        <= 1'b0;
      end else begin
         pct_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  chan      <= {blue_cnt, green_cnt, red_cnt};
                  busy      <= 1'b1;
                  zero_pend <= 1'b0;
                  err_pend  <= 1'b0;
                  state     <= SUM;
               end
            end
            SUM: begin
               total <= TOT_W'(chan[CH_RED]) + TOT_W'(chan[CH_GREEN]) + TOT_W'(chan[CH_BLUE]);
               state <= SCALE;
            end
            SCALE: begin
               if (total == '0) begin
                  res       <= '0;
                  zero_pend <= 1'b1;
                  state     <= DONE;
               end else if (total > MAX_T) begin
                  // halving all three keeps the ratios while bounding 100*cnt
                  for (int i = 0; i < 3; i++) chan[i] <= chan[i] >> 1;
                  state <= SUM;
               end else begin
                  idx          <= CH_RED;
                  div.dividend <= DIV_W'(chan[CH_RED]);
                  div.divisor  <= DIV_W'(total);
                  div.per_on   <= 1'b1;
                  state        <= LAUNCH;
               end
            end
            LAUNCH: begin
               state <= WAIT;
            end
            WAIT: begin
               if (div.per_done) begin
                  res[idx]   <= div.percentage;
                  div.per_on <= 1'b0;
                  state      <= GAP;
               end else if (tmr_expired) begin
                  div.per_on <= 1'b0;
                  res        <= '0;
                  err_pend   <= 1'b1;
                  state      <= DONE;
               end
            end
            GAP: begin
               if (idx == CH_BLUE) begin
                  state <= DONE;
               end else begin
                  idx          <= idx_nxt;
                  div.dividend <= DIV_W'(chan[idx_nxt]);
                  div.per_on   <= 1'b1;
                  state        <= LAUNCH;
               end
            end
            DONE: begin
               red_pct   <= res[CH_RED];
               green_pct <= res[CH_GREEN];
               blue_pct  <= res[CH_BLUE];
               zero_flag <= zero_pend;
               error     <= err_pend;
               pct_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_color_percent_scheduler.sv
// Scoreboard bench: directed runs push expected results, a negedge monitor
// pops and compares on every pct_valid. Includes a simple divider model.
module tb_color_percent_scheduler;
   import color_pkg::*;

   localparam int COUNT_W = 16;

   typedef struct {
      int r, g, b, zf, er;
   } exp_t;

   logic               CLK100MHZ = 1'b0;
   logic               reset_n   = 1'b0;
   logic               start     = 1'b0;
   logic [COUNT_W-1:0] red_cnt   = '0;
   logic [COUNT_W-1:0] green_cnt = '0;
   logic [COUNT_W-1:0] blue_cnt  = '0;
   logic [PCT_W-1:0]   red_pct, green_pct, blue_pct;
   logic               pct_valid, busy, zero_flag, error;

   color_percent_scheduler_if div_if ();

   color_percent_scheduler #(
      .COUNT_W(COUNT_W), .MAX_TOTAL(5000), .TIMEOUT(255), .TMR_W(8)
   ) dut (
      .CLK100MHZ (CLK100MHZ),
      .reset_n   (reset_n),
      .start     (start),
      .red_cnt   (red_cnt),
      .green_cnt (green_cnt),
      .blue_cnt  (blue_cnt),
      .div       (div_if),
      .red_pct   (red_pct),
      .green_pct (green_pct),
      .blue_pct  (blue_pct),
      .pct_valid (pct_valid),
      .busy      (busy),
      .zero_flag (zero_flag),
      .error     (error)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   int   n_chk  = 0;
   int   n_pass = 0;
   exp_t sb[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // divider model: result 4 enabled cycles after per_on rises, held until per_on drops
   logic hang = 1'b0;
   int   dcnt;

   function automatic logic [PCT_W-1:0] div_calc(input logic [DIV_W-1:0] a, input logic [DIV_W-1:0] b);
      int unsigned n;
      if (b == '0) return '0;
      n = 100 * int'(a) + int'(b) / 2;
      return PCT_W'(n / int'(b));
   endfunction

   always @(posedge CLK100MHZ or negedge reset_n) begin
      if (!reset_n) begin
         dcnt              <= 0;
         div_if.per_done   <= 1'b0;
         div_if.percentage <= '0;
      end else if (!div_if.per_on) begin
         dcnt            <= 0;
         div_if.per_done <= 1'b0;
      end else if (!hang) begin
         dcnt <= dcnt + 1;
         if (dcnt == 3) begin
            div_if.per_done   <= 1'b1;
            div_if.percentage <= div_calc(div_if.dividend, div_if.divisor);
         end
      end
   end

   // per_on activity tracker
   logic prev_on  = 1'b0;
   int   rise_cnt = 0;
   int   gap_len  = 0;
   int   on_len   = 0;
   int   last_on_len = 0;
   int   last_div = 0;
   bit   gap_chk  = 1'b0;
   bit   ever_on  = 1'b0;
   int   n_valid  = 0;

   always @(negedge CLK100MHZ) begin
      if (div_if.per_on) begin
         ever_on = 1'b1;
         if (!prev_on) begin
            if (gap_chk && rise_cnt > 0) chk("per_on_gap_len", gap_len, 1);
            rise_cnt = rise_cnt + 1;
            last_div = int'(div_if.divisor);
            on_len   = 0;
         end
         on_len = on_len + 1;
      end else begin
         if (prev_on) begin
            gap_len     = 0;
            last_on_len = on_len;
         end
         gap_len = gap_len + 1;
      end
      prev_on = div_if.per_on;
   end

   // scoreboard monitor
   always @(negedge CLK100MHZ) begin
      if (pct_valid) begin
         exp_t e;
         n_valid = n_valid + 1;
         chk("sb_has_entry", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("red_pct",   int'(red_pct),   e.r);
            chk("green_pct", int'(green_pct), e.g);
            chk("blue_pct",  int'(blue_pct),  e.b);
            chk("zero_flag", int'(zero_flag), e.zf);
            chk("error",     int'(error),     e.er);
            chk("busy_at_valid", int'(busy),  0);
         end
      end
   end

   task automatic push(input int r, input int g, input int b, input int zf, input int er);
      exp_t e;
      e.r = r; e.g = g; e.b = b; e.zf = zf; e.er = er;
      sb.push_back(e);
   endtask

   task automatic do_start(input int r, input int g, input int b);
      @(posedge CLK100MHZ); #1;
      red_cnt   = COUNT_W'(r);
      green_cnt = COUNT_W'(g);
      blue_cnt  = COUNT_W'(b);
      start     = 1'b1;
      @(posedge CLK100MHZ); #1;
      start     = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while ((sb.size() != 0 || busy) && k < budget) begin
         @(posedge CLK100MHZ); #1;
         k++;
      end
      repeat (2) @(posedge CLK100MHZ);
      #1;
      chk("run_complete", int'(sb.size()), 0);
   endtask

   initial begin
      int lat;

      // reset state
      #12;
      chk("rst_per_on",    int'(div_if.per_on), 0);
      chk("rst_pct_valid", int'(pct_valid), 0);
      chk("rst_busy",      int'(busy), 0);
      chk("rst_red_pct",   int'(red_pct), 0);
      chk("rst_zero_flag", int'(zero_flag), 0);
      chk("rst_error",     int'(error), 0);
      @(posedge CLK100MHZ); #1;
      reset_n = 1'b1;

      // equal split, no scaling
      n_valid = 0; rise_cnt = 0;
      push(33, 33, 33, 0, 0);
      do_start(1000, 1000, 1000);
      chk("busy_after_start", int'(busy), 1);
      wait_idle(500);
      chk("eq_valid_pulses", n_valid, 1);
      chk("eq_divides", rise_cnt, 3);
      chk("eq_divisor", last_div, 3000);

      // unequal split, one-cycle gap between channels
      n_valid = 0; rise_cnt = 0; gap_chk = 1'b1;
      push(50, 25, 25, 0, 0);
      do_start(2000, 1000, 1000);
      wait_idle(500);
      gap_chk = 1'b0;
      chk("uneq_valid_pulses", n_valid, 1);

      // two scale shifts: 12000 -> 6000 -> 3000
      n_valid = 0;
      push(33, 33, 33, 0, 0);
      do_start(4000, 4000, 4000);
      wait_idle(500);
      chk("scaled_divisor", last_div, 3000);
      chk("scaled_dividend", int'(div_if.dividend), 1000);

      // zero total: no divider activity, quick completion
      ever_on = 1'b0; n_valid = 0;
      push(0, 0, 0, 1, 0);
      do_start(0, 0, 0);
      lat = 0;
      for (int k = 1; k <= 4; k++) begin
         if (lat == 0) begin
            @(posedge CLK100MHZ); #1;
            if (pct_valid) lat = k;
         end
      end
      chk("zero_latency_le4", int'(lat >= 1 && lat <= 4), 1);
      wait_idle(50);
      chk("zero_per_on_never", int'(ever_on), 0);

      // divider never answers: timeout on red after 256 WAIT cycles
      hang = 1'b1; n_valid = 0;
      push(0, 0, 0, 0, 1);
      do_start(1000, 1000, 1000);
      wait_idle(1000);
      hang = 1'b0;
      chk("timeout_per_on_len", last_on_len, 257);

      // next good run clears error
      push(33, 33, 33, 0, 0);
      do_start(1000, 1000, 1000);
      wait_idle(500);
      chk("error_cleared", int'(error), 0);

      // second start while busy is ignored
      n_valid = 0;
      push(50, 25, 25, 0, 0);
      do_start(2000, 1000, 1000);
      repeat (5) @(posedge CLK100MHZ);
      #1;
      chk("busy_mid_run", int'(busy), 1);
      do_start(0, 0, 0);
      wait_idle(500);
      repeat (10) @(posedge CLK100MHZ);
      #1;
      chk("ignored_valid_pulses", n_valid, 1);
      chk("held_red_pct",   int'(red_pct), 50);
      chk("held_green_pct", int'(green_pct), 25);
      chk("held_zero_flag", int'(zero_flag), 0);

      // asynchronous reset during green WAIT
      rise_cnt = 0;
      do_start(1000, 1000, 1000);
      lat = 0;
      while (rise_cnt < 2 && lat < 200) begin
         @(posedge CLK100MHZ); #1;
         lat++;
      end
      chk("reached_green", rise_cnt, 2);
      @(posedge CLK100MHZ); #1;
      @(posedge CLK100MHZ); #3;
      chk("pre_rst_per_on", int'(div_if.per_on), 1);
      reset_n = 1'b0;
      #1;
      chk("async_per_on",  int'(div_if.per_on), 0);
      chk("async_busy",    int'(busy), 0);
      chk("async_red_pct", int'(red_pct), 0);
      chk("async_green_pct", int'(green_pct), 0);
      chk("async_dividend", int'(div_if.dividend), 0);
      @(posedge CLK100MHZ); #1;
      reset_n = 1'b1;
      repeat (3) @(posedge CLK100MHZ);
      #1;
      chk("sb_drained", int'(sb.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
